// File: rtl/d_d_x_sched_pkg.sv
// Shared widths and FSM encoding for the d_d_x gradient-unit sequencer.
package d_d_x_sched_pkg;

  localparam int DATABIT = 16;  // Q2.14, matches d_d_x
  localparam int ADDR_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/d_d_x_tag_fifo.sv
// Small synchronous FIFO holding element indices of in-flight d_d_x operations.
// DEPTH must be a power of two, at least 2.
module d_d_x_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wptr_q, rptr_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign rdata_o = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/d_d_x_sched.sv
// Sequences one shared d_d_x unit across a vector of elements: credit-paced operand
// reads, in-order result write-back, and a watchdog for lost or spurious results.
module d_d_x_sched
  import d_d_x_sched_pkg::*;
#(
  parameter int MAX_OUT = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    num_elem,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               dx_en,
  input  logic               dx_valid,
  input  logic [DATABIT-1:0] dx_out,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATABIT-1:0] wr_data
);

  localparam int CW  = $clog2(MAX_OUT) + 1;
  localparam int WDW = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic                error_q, error_d;
  logic                dx_en_q;
  logic [ADDR_W-1:0]   tag_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATABIT-1:0]  wr_data_q;

  logic                busy_st, issue, pop, spur, stall, tmo, err_evt;
  logic                fifo_empty, fifo_full;
  logic [ADDR_W-1:0]   fifo_head;

  assign busy_st = (state_q != S_IDLE);
  assign issue   = (state_q == S_ISSUE) && (credit_q != '0) && (idx_q < count_q);
  assign pop     = busy_st && dx_valid && !fifo_empty;
  assign spur    = busy_st && dx_valid && fifo_empty;
  assign stall   = busy_st && !fifo_empty && !dx_valid;
  assign tmo     = stall && (wd_q == WDW'(TIMEOUT - 1));
  assign err_evt = spur || tmo;

  d_d_x_tag_fifo #(.DEPTH(MAX_OUT), .W(ADDR_W)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dx_en_q && !fifo_full),
    .pop_i   (pop),
    .flush_i (err_evt),
    .wdata_i (tag_q),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    wr_cnt_d = wr_cnt_q + {{ADDR_W{1'b0}}, pop};
    error_d  = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d  = 1'b0;
          count_d  = num_elem;
          idx_d    = '0;
          wr_cnt_d = '0;
          state_d  = (num_elem == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (idx_q + 1'b1 == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (wr_cnt_q == count_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An abort still passes through DONE so the parent sees a done pulse.
    if (err_evt) begin
      error_d = 1'b1;
      state_d = (state_q == S_DONE) ? S_IDLE : S_DONE;
    end
  end

  always_comb begin
    credit_d = credit_q + CW'(pop) - CW'(issue);
    if (err_evt) credit_d = CW'(MAX_OUT);
    wd_d = stall ? wd_q + 1'b1 : '0;
    if (err_evt) wd_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      wr_cnt_q  <= '0;
      credit_q  <= CW'(MAX_OUT);
      wd_q      <= '0;
      error_q   <= 1'b0;
      dx_en_q   <= 1'b0;
      tag_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      wr_cnt_q <= wr_cnt_d;
      credit_q <= credit_d;
      wd_q     <= wd_d;
      error_q  <= error_d;
      // A read issued in the abort cycle is never handed to d_d_x.
      dx_en_q  <= issue && !err_evt;
      if (issue) tag_q <= idx_q[ADDR_W-1:0];
      wr_en_q  <= pop;
      if (pop) begin
        wr_addr_q <= fifo_head;
        wr_data_q <= dx_out;
      end
    end
  end

  assign busy    = busy_st;
  assign done    = (state_q == S_DONE);
  assign error   = error_q;
  assign rd_en   = issue;
  assign rd_addr = idx_q[ADDR_W-1:0];
  assign dx_en   = dx_en_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_d_d_x_sched.sv
// Bench for d_d_x_sched: in-order d_d_x responder with random latency, a transaction-level
// reference model checked every cycle, and directed runs with literal timing expectations.
module tb_d_d_x_sched;
  import d_d_x_sched_pkg::*;

  localparam int MAX_OUT = 8;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [ADDR_W:0]    num_elem = '0;
  logic               dx_valid = 1'b0;
  logic [DATABIT-1:0] dx_out = '0;
  logic               busy, done, error, rd_en, dx_en, wr_en;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [DATABIT-1:0] wr_data;

  always #5 clk = ~clk;

  d_d_x_sched #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_elem(num_elem),
    .busy(busy), .done(done), .error(error),
    .rd_en(rd_en), .rd_addr(rd_addr), .dx_en(dx_en),
    .dx_valid(dx_valid), .dx_out(dx_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- d_d_x responder (results in order, random latency) ----------------
  int lat_lo = 6, lat_hi = 6, drop_op = -1;
  int spur_req = 0, spur_ack = 0;
  int rcyc = 0, ops = 0, last_due = 0;
  int due_q[$];
  logic [DATABIT-1:0] dat_q[$];

  initial begin : responder
    forever begin
      @(posedge clk); #2;
      rcyc++;
      if (rst) begin
        due_q.delete(); dat_q.delete();
        dx_valid = 1'b0;
        continue;
      end
      if (start && !busy) ops = 0;
      if (dx_en) begin
        if (ops != drop_op) begin
          int d;
          d = rcyc + int'($urandom_range(lat_hi, lat_lo));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          due_q.push_back(d);
          dat_q.push_back(DATABIT'($urandom));
        end
        ops++;
      end
      dx_valid = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        dx_valid = 1'b1;
        dx_out   = DATABIT'($urandom);
      end else if (due_q.size() != 0 && due_q[0] == rcyc) begin
        void'(due_q.pop_front());
        dx_valid = 1'b1;
        dx_out   = dat_q.pop_front();
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit m_busy, m_done, m_err, m_dx, m_wen;
  int m_n, m_iss, m_wr, m_infl, m_wd, m_dxtag;
  logic [ADDR_W-1:0]  m_waddr;
  logic [DATABIT-1:0] m_wdata;
  int q[$];
  int ncyc = 0;
  // per-run observations of the DUT, used for literal expectations
  int st_start, st_done, st_rd_n, st_rd_first, st_rd_last, st_wr_n, st_wr_last;
  int st_busy_n, st_out, st_max_out, st_last_valid;
  bit st_done_seen;

  initial begin : model
    bit exp_rd, pop, spur, stall, err, fin;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        chk("rst_outputs", {busy, done, error, rd_en, dx_en, wr_en, rd_addr, wr_addr, wr_data}, '0);
        m_busy = 0; m_done = 0; m_err = 0; m_dx = 0; m_wen = 0;
        m_n = 0; m_iss = 0; m_wr = 0; m_infl = 0; m_wd = 0;
        q.delete();
        continue;
      end
      exp_rd = m_busy && !m_done && (m_iss < m_n) && (m_infl < MAX_OUT);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("rd_en", rd_en, exp_rd);
      if (exp_rd) chk("rd_addr", rd_addr, m_iss);
      chk("dx_en", dx_en, m_dx);
      chk("wr_en", wr_en, m_wen);
      if (m_wen) begin
        chk("wr_addr", wr_addr, m_waddr);
        chk("wr_data", wr_data, m_wdata);
      end
      // observations
      if (busy) st_busy_n++;
      if (rd_en) begin
        if (st_rd_n == 0) st_rd_first = ncyc;
        st_rd_last = ncyc; st_rd_n++; st_out++;
      end
      if (wr_en) begin st_wr_n++; st_wr_last = ncyc; end
      if (done) begin st_done = ncyc; st_done_seen = 1; end
      if (busy && dx_valid) begin
        st_last_valid = ncyc;
        if (q.size() != 0) st_out--;
      end
      if (st_out > st_max_out) st_max_out = st_out;
      // advance the model by one cycle
      pop   = m_busy && dx_valid && q.size() != 0;
      spur  = m_busy && dx_valid && q.size() == 0;
      stall = m_busy && q.size() != 0 && !dx_valid;
      m_wd  = stall ? m_wd + 1 : 0;
      err   = spur || (stall && m_wd == TIMEOUT);
      fin   = m_busy && !m_done && m_iss == m_n && m_wr == m_n;
      m_wen = pop;
      if (pop) begin
        m_waddr = ADDR_W'(q.pop_front());
        m_wdata = dx_out;
        m_wr++; m_infl--;
      end
      if (m_dx) q.push_back(m_dxtag);
      m_dx = exp_rd && !err;
      m_dxtag = m_iss;
      if (exp_rd) begin m_iss++; m_infl++; end
      if (err) begin q.delete(); m_infl = 0; m_err = 1; m_wd = 0; end
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_err = 0; m_n = int'(num_elem);
          m_iss = 0; m_wr = 0; m_done = (num_elem == 0);
          st_start = ncyc; st_rd_n = 0; st_wr_n = 0; st_busy_n = 0;
          st_out = 0; st_max_out = 0; st_done_seen = 0;
        end
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (err || fin) begin
        m_done = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_start(input int n, input bit spur, input bit extra);
    @(posedge clk); #1;
    start = 1'b1; num_elem = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (spur) spur_req++;
    if (extra) begin
      @(posedge clk); #1; start = 1'b1; num_elem = 1;
      @(posedge clk); #1; start = 1'b0;
    end
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!st_done_seen && k < 4000) begin @(posedge clk); k++; end
    chk({nm, "_done_seen"}, st_done_seen, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n;
    bit hit;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // four elements, latency 6: back-to-back reads, done one cycle after the last write
    run_start(4, 0, 0); wait_done("t1");
    chk("t1_rd_n", st_rd_n, 4);
    chk("t1_first_rd", st_rd_first - st_start, 1);
    chk("t1_rd_span", st_rd_last - st_rd_first, 3);
    chk("t1_wr_n", st_wr_n, 4);
    chk("t1_done_after_wr", st_done - st_wr_last, 1);
    chk("t1_done_lat", st_done - st_start, 13);

    // twenty elements, latency 6: credits never run out
    run_start(20, 0, 0); wait_done("t2a");
    chk("t2a_rd_span", st_rd_last - st_rd_first, 19);
    chk("t2a_wr_n", st_wr_n, 20);

    // zero elements: one busy cycle which is the done cycle
    run_start(0, 0, 0); wait_done("t3");
    chk("t3_done_lat", st_done - st_start, 1);
    chk("t3_busy_n", st_busy_n, 1);
    chk("t3_rd_n", st_rd_n, 0);
    chk("t3_wr_n", st_wr_n, 0);

    // spurious result while busy with nothing in flight
    run_start(0, 1, 0); wait_done("t4");
    chk("t4_error", error, 1);
    chk("t4_wr_n", st_wr_n, 0);
    run_start(2, 0, 0);
    chk("t4_error_cleared", error, 0);
    wait_done("t4b");
    chk("t4b_wr_n", st_wr_n, 2);

    // lost result: watchdog fires TIMEOUT cycles after the last good result
    drop_op = 2;
    run_start(3, 0, 0); wait_done("t5");
    drop_op = -1;
    chk("t5_error", error, 1);
    chk("t5_wr_n", st_wr_n, 2);
    chk("t5_timeout_lat", st_done - st_last_valid, TIMEOUT + 1);

    // latency 12 after the abort: all credits back, exactly MAX_OUT in flight, then stalls
    lat_lo = 12; lat_hi = 12;
    run_start(20, 0, 0); wait_done("t2b");
    chk("t2b_max_out", st_max_out, MAX_OUT);
    chk("t2b_stalled", (st_rd_last - st_rd_first) > 19, 1);
    chk("t2b_wr_n", st_wr_n, 20);
    chk("t2b_error_cleared", error, 0);

    // start while busy is ignored
    lat_lo = 6; lat_hi = 6;
    run_start(20, 0, 1); wait_done("t6a");
    chk("t6a_wr_n", st_wr_n, 20);

    // async reset in the middle of issue
    run_start(20, 0, 0);
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(posedge clk); #1;
      if (rd_en && rd_addr == 5) hit = 1;
    end
    chk("t6_reached_idx5", hit, 1);
    #2 rst = 1'b1;
    #1 chk("t6_rst_immediate", {busy, done, error, rd_en, dx_en, wr_en, rd_addr, wr_addr, wr_data}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_start(3, 0, 0); wait_done("t6b");
    chk("t6b_rd_n", st_rd_n, 3);
    chk("t6b_wr_n", st_wr_n, 3);

    // randomized runs, including the full 2**ADDR_W element count
    for (int i = 0; i < 12; i++) begin
      n = (i == 0) ? (1 << ADDR_W) : int'($urandom_range(1 << ADDR_W, 1));
      lat_lo = int'($urandom_range(8, 1));
      lat_hi = lat_lo + int'($urandom_range(20, 0));
      run_start(n, 0, bit'($urandom_range(1, 0)));
      wait_done("rand");
      chk("rand_wr_n", st_wr_n, n);
      chk("rand_error", error, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
